// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers results from ALU (s0), load unit (s1) and
// mul/div (s2) in per-source FIFOs and issues one registered writeback per
// cycle, granting the non-empty sources in round-robin order.
module wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s0_valid_i,
    output logic        s0_ready_o,
    input  logic [4:0]  s0_rd_i,
    input  logic [31:0] s0_data_i,
    input  logic        s1_valid_i,
    output logic        s1_ready_o,
    input  logic [4:0]  s1_rd_i,
    input  logic [31:0] s1_data_i,
    input  logic        s2_valid_i,
    output logic        s2_ready_o,
    input  logic [4:0]  s2_rd_i,
    input  logic [31:0] s2_data_i,
    output logic        wb_o,
    output logic [4:0]  wb_r_o,
    output logic [31:0] result_o,
    output logic [1:0]  grant_o,
    output logic        busy_o
);

    // FIFO entry layout: {rd[4:0], data[31:0]}
    localparam int ENT_W = 37;
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    logic [2:0]       vld_p0;
    logic [2:0]       ready;
    logic [2:0]       push;
    logic [2:0]       pop;
    logic [2:0]       nonempty;
    logic [ENT_W-1:0] in_ent [3];
    logic [ENT_W-1:0] mem [3][DEPTH];
    logic [PTR_W:0]   count [3];
    logic [PTR_W-1:0] wr_ptr [3];
    logic [PTR_W-1:0] rd_ptr [3];
    logic [1:0]       rr_ptr;
    logic [1:0]       sel_p0;
    logic             any_p0;
    logic [ENT_W-1:0] head_p0;

    // Round-robin successor over the three sources.
    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    assign vld_p0    = {s2_valid_i, s1_valid_i, s0_valid_i};
    assign in_ent[0] = {s0_rd_i, s0_data_i};
    assign in_ent[1] = {s1_rd_i, s1_data_i};
    assign in_ent[2] = {s2_rd_i, s2_data_i};

    assign s0_ready_o = ready[0];
    assign s1_ready_o = ready[1];
    assign s2_ready_o = ready[2];

    // Ready and occupancy decode purely from registered counts, so the pop
    // side never feeds combinationally back into a source's ready.
    always_comb begin
        ready    = '0;
        nonempty = '0;
        push     = '0;
        for (int i = 0; i < 3; i++) begin
            ready[i]    = (count[i] != FULL);
            nonempty[i] = (count[i] != '0);
            push[i]     = vld_p0[i] && (count[i] != FULL);
        end
    end

    // Round-robin search starting at rr_ptr; first non-empty FIFO wins.
    always_comb begin
        logic [1:0] cand;
        sel_p0  = 2'd0;
        any_p0  = 1'b0;
        head_p0 = '0;
        pop     = '0;
        cand    = rr_ptr;
        for (int k = 0; k < 3; k++) begin
            if (!any_p0 && nonempty[cand]) begin
                any_p0  = 1'b1;
                sel_p0  = cand;
                head_p0 = mem[cand][rd_ptr[cand]];
            end
            cand = inc3(cand);
        end
        for (int i = 0; i < 3; i++) begin
            pop[i] = any_p0 && (sel_p0 == 2'(i));
        end
    end

    // FIFO pointers and counts; simultaneous push and pop leaves count as is.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                count[i]  <= '0;
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + 1'b1;
                    2'b01:   count[i] <= count[i] - 1'b1;
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // FIFO storage; contents are only meaningful below the count, so no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= in_ent[i];
        end
    end

    // Registered writeback beat; fields are zero whenever no source is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_o     <= 1'b0;
            wb_r_o   <= '0;
            result_o <= '0;
            grant_o  <= '0;
            rr_ptr   <= '0;
        end else begin
            wb_o     <= any_p0;
            wb_r_o   <= head_p0[ENT_W-1 -: 5];
            result_o <= head_p0[31:0];
            grant_o  <= sel_p0;
            if (any_p0) rr_ptr <= inc3(sel_p0);
        end
    end

    assign busy_o = (|nonempty) | wb_o;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: hand-computed vector table, directed
// multi-cycle sequences, and randomized traffic against a queue-based model.
module tb_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int PTR_W = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vld [3];
    logic        rdy [3];
    logic [4:0]  rdv [3];
    logic [31:0] dat [3];
    logic        wb;
    logic [4:0]  wb_r;
    logic [31:0] result;
    logic [1:0]  grant;
    logic        busy;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // reference model state
    logic [36:0] mq [3][$];
    int          m_rr;

    always #5 clk = ~clk;

    wb_arbiter #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .s0_valid_i (vld[0]),
        .s0_ready_o (rdy[0]),
        .s0_rd_i    (rdv[0]),
        .s0_data_i  (dat[0]),
        .s1_valid_i (vld[1]),
        .s1_ready_o (rdy[1]),
        .s1_rd_i    (rdv[1]),
        .s1_data_i  (dat[1]),
        .s2_valid_i (vld[2]),
        .s2_ready_o (rdy[2]),
        .s2_rd_i    (rdv[2]),
        .s2_data_i  (dat[2]),
        .wb_o       (wb),
        .wb_r_o     (wb_r),
        .result_o   (result),
        .grant_o    (grant),
        .busy_o     (busy)
    );

    typedef struct {
        logic [2:0]  v;
        logic [4:0]  r0, r1, r2;
        logic [31:0] d0, d1, d2;
        logic        e_wb;
        logic [4:0]  e_rd;
        logic [31:0] e_res;
        logic [1:0]  e_gr;
        logic        e_busy;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_wb(input string name, input logic e_wb, input logic [4:0] e_rd,
                            input logic [31:0] e_res, input logic [1:0] e_gr);
        check({name, ".wb"},     32'(wb),     32'(e_wb));
        check({name, ".rd"},     32'(wb_r),   32'(e_rd));
        check({name, ".result"}, result,      e_res);
        check({name, ".grant"},  32'(grant),  32'(e_gr));
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 3; i++) begin
            vld[i] = 1'b0;
            rdv[i] = '0;
            dat[i] = '0;
        end
    endtask

    // Reset DUT and model; returns at a falling edge with rst released.
    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        for (int i = 0; i < 3; i++) mq[i].delete();
        m_rr = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock of traffic checked against the model. Inputs must already be
    // applied; returns 1 ps after the rising edge with the accepted pushes.
    task automatic tick(output logic [2:0] acc);
        int          g;
        logic [36:0] ent;
        logic        e_wb;
        logic [4:0]  e_rd;
        logic [31:0] e_res;
        logic [1:0]  e_gr;
        logic        e_busy;
        logic [36:0] in_ent [3];
        for (int i = 0; i < 3; i++) begin
            check($sformatf("ready%0d", i), 32'(rdy[i]), 32'(mq[i].size() != DEPTH));
            acc[i]    = vld[i] && (mq[i].size() != DEPTH);
            in_ent[i] = {rdv[i], dat[i]};
        end
        g = -1;
        for (int k = 0; k < 3; k++) begin
            int c;
            c = (m_rr + k) % 3;
            if (g < 0 && mq[c].size() > 0) g = c;
        end
        @(posedge clk);
        #1;
        e_wb = 1'b0; e_rd = '0; e_res = '0; e_gr = '0;
        if (g >= 0) begin
            ent   = mq[g].pop_front();
            e_wb  = 1'b1;
            e_rd  = ent[36:32];
            e_res = ent[31:0];
            e_gr  = 2'(g);
            m_rr  = (g + 1) % 3;
        end
        for (int i = 0; i < 3; i++) if (acc[i]) mq[i].push_back(in_ent[i]);
        e_busy = e_wb;
        for (int i = 0; i < 3; i++) if (mq[i].size() > 0) e_busy = 1'b1;
        check_wb("model", e_wb, e_rd, e_res, e_gr);
        check("model.busy", 32'(busy), 32'(e_busy));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] acc;
        logic [1:0] exp_gr [5];
        logic [4:0] exp_rd [5];

        clear_inputs();

        // ---- table: single result, simultaneous push after rr=2, x0 beat
        tbl[0] = '{3'b010, 5'd0, 5'd5, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0,  1'b0, 5'd0, 32'h0,        2'd0, 1'b1};
        tbl[1] = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0,        32'h0,  1'b1, 5'd5, 32'hDEADBEEF, 2'd1, 1'b1};
        tbl[2] = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0,        32'h0,  1'b0, 5'd0, 32'h0,        2'd0, 1'b0};
        tbl[3] = '{3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22,      32'h33, 1'b0, 5'd0, 32'h0,        2'd0, 1'b1};
        tbl[4] = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0,        32'h0,  1'b1, 5'd3, 32'h33,       2'd2, 1'b1};
        tbl[5] = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0,        32'h0,  1'b1, 5'd1, 32'h11,       2'd0, 1'b1};
        tbl[6] = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0,        32'h0,  1'b1, 5'd2, 32'h22,       2'd1, 1'b1};
        tbl[7] = '{3'b001, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0, 32'h0,  1'b0, 5'd0, 32'h0,        2'd0, 1'b1};
        tbl[8] = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0,        32'h0,  1'b1, 5'd0, 32'hFFFFFFFF, 2'd0, 1'b1};
        tbl[9] = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0,        32'h0,  1'b0, 5'd0, 32'h0,        2'd0, 1'b0};

        do_reset();
        check("reset.wb",   32'(wb),   32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) check($sformatf("reset.ready%0d", i), 32'(rdy[i]), 32'd1);

        for (int n = 0; n < 10; n++) begin
            vld[0] = tbl[n].v[0]; vld[1] = tbl[n].v[1]; vld[2] = tbl[n].v[2];
            rdv[0] = tbl[n].r0;   rdv[1] = tbl[n].r1;   rdv[2] = tbl[n].r2;
            dat[0] = tbl[n].d0;   dat[1] = tbl[n].d1;   dat[2] = tbl[n].d2;
            @(posedge clk);
            #1;
            check_wb($sformatf("tbl%0d", n), tbl[n].e_wb, tbl[n].e_rd, tbl[n].e_res, tbl[n].e_gr);
            check($sformatf("tbl%0d.busy", n), 32'(busy), 32'(tbl[n].e_busy));
        end
        clear_inputs();

        // ---- simultaneous push from reset: grants 0,1,2 then rr back at 0
        do_reset();
        for (int i = 0; i < 3; i++) begin
            vld[i] = 1'b1;
            rdv[i] = 5'(i + 1);
            dat[i] = 32'(8'h11 * (i + 1));
        end
        @(posedge clk); #1;
        clear_inputs();
        exp_gr[0] = 2'd0; exp_gr[1] = 2'd1; exp_gr[2] = 2'd2;
        exp_rd[0] = 5'd1; exp_rd[1] = 5'd2; exp_rd[2] = 5'd3;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            check_wb($sformatf("simul%0d", n), 1'b1, exp_rd[n], 32'(8'h11 * (n + 1)), exp_gr[n]);
        end
        // rr=0 grants s0 before s2; any other pointer would pick s2 first
        vld[0] = 1'b1; rdv[0] = 5'd9;  dat[0] = 32'h99;
        vld[2] = 1'b1; rdv[2] = 5'd10; dat[2] = 32'hAA;
        @(posedge clk); #1;
        clear_inputs();
        @(posedge clk); #1;
        check_wb("rr0.first", 1'b1, 5'd9, 32'h99, 2'd0);
        @(posedge clk); #1;
        check_wb("rr0.second", 1'b1, 5'd10, 32'hAA, 2'd2);
        @(posedge clk); #1;
        check_wb("rr0.idle", 1'b0, 5'd0, 32'h0, 2'd0);

        // ---- asynchronous reset mid-cycle with a beat live and one buffered
        do_reset();
        vld[0] = 1'b1; rdv[0] = 5'd7; dat[0] = 32'hA1;
        @(posedge clk); #1;
        rdv[0] = 5'd8; dat[0] = 32'hA2;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        check_wb("prerst", 1'b1, 5'd7, 32'hA1, 2'd0);
        check("prerst.busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_wb("asyncrst", 1'b0, 5'd0, 32'h0, 2'd0);
        check("asyncrst.busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) check($sformatf("asyncrst.ready%0d", i), 32'(rdy[i]), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            check($sformatf("postrst%0d.wb", n), 32'(wb), 32'd0);
            check($sformatf("postrst%0d.busy", n), 32'(busy), 32'd0);
        end

        // ---- saturation: all sources valid for 12 cycles, rd advancing on accept
        do_reset();
        for (int i = 0; i < 3; i++) begin
            vld[i] = 1'b1;
            rdv[i] = 5'(i * 8);
            dat[i] = 32'h1000 * (i + 1);
        end
        for (int c = 0; c < 12; c++) begin
            tick(acc);
            for (int i = 0; i < 3; i++) if (acc[i]) begin
                rdv[i] = rdv[i] + 5'd1;
                dat[i] = dat[i] + 32'd1;
            end
        end
        clear_inputs();
        for (int c = 0; c < 8; c++) tick(acc);

        // ---- randomized traffic; sources hold rd/data until accepted
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!vld[i] && $urandom_range(0, 2) != 0) begin
                    vld[i] = 1'b1;
                    rdv[i] = 5'($urandom);
                    dat[i] = $urandom;
                end
            end
            tick(acc);
            for (int i = 0; i < 3; i++) if (acc[i]) vld[i] = 1'b0;
        end
        clear_inputs();
        for (int c = 0; c < 10; c++) tick(acc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
